// File: rtl/clock_pkg.sv
// Shared types and default timing for the clock button conditioning stage.
package clock_pkg;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESS,
    HOLD,
    REPEAT,
    RELEASE
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYC     = 500000;
  localparam int DEF_REPEAT_DELAY_CYC = 25000000;
  localparam int DEF_REPEAT_RATE_CYC  = 5000000;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, debounce FSM, optional
// hold-to-auto-repeat, and a registered single-cycle pulse output.
module button_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
  parameter bit REPEAT_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  localparam int CNT_W = $clog2(max_of3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYC - 1);

  logic [1:0]       sync_q;
  logic             synced;
  btn_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pulse_next;

  assign synced = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
      state  <= ARM;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key};
      state  <= next_state;
      cnt    <= cnt_next;
      pulse  <= pulse_next;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ARM:     if (!synced && cnt == DEB_LAST) next_state = IDLE;
      IDLE:    if (synced) next_state = PRESS;
      PRESS: begin
        if (!synced)               next_state = IDLE;
        else if (cnt == DEB_LAST)  next_state = REPEAT_EN ? HOLD : RELEASE;
      end
      HOLD: begin
        if (!synced)               next_state = RELEASE;
        else if (cnt == DLY_LAST)  next_state = REPEAT;
      end
      REPEAT:  if (!synced) next_state = RELEASE;
      RELEASE: if (!synced && cnt == DEB_LAST) next_state = IDLE;
      default: next_state = ARM;
    endcase
  end

  // The counter restarts on every state change and on every sample that breaks a run.
  always_comb begin
    cnt_next   = cnt + CNT_W'(1);
    pulse_next = 1'b0;
    case (state)
      ARM, RELEASE: if (synced || cnt == DEB_LAST) cnt_next = '0;
      IDLE:         cnt_next = '0;
      PRESS: begin
        if (!synced) cnt_next = '0;
        else if (cnt == DEB_LAST) begin
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      HOLD: begin
        if (!synced) cnt_next = '0;
        else if (cnt == DLY_LAST) begin
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      REPEAT: begin
        if (!synced) cnt_next = '0;
        else if (cnt == RATE_LAST) begin
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      default: cnt_next = '0;
    endcase
  end

endmodule

// File: rtl/clock_button_ctrl.sv
// Conditions the minute, hour and 12/24 mode buttons into clean one-cycle
// pulses for the time-of-day counter; mode never auto-repeats.
module clock_button_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_min,
  input  logic key_hr,
  input  logic key_tmod,
  output logic set_min,
  output logic set_hr,
  output logic set_TMOD
);

  button_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1)
  ) u_min (
    .clk(clk), .rst(rst), .key(key_min), .pulse(set_min)
  );

  button_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1)
  ) u_hr (
    .clk(clk), .rst(rst), .key(key_hr), .pulse(set_hr)
  );

  button_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b0)
  ) u_tmod (
    .clk(clk), .rst(rst), .key(key_tmod), .pulse(set_TMOD)
  );

endmodule
